// File: rtl/led_fade_sequencer.sv
// rtl/led_fade_sequencer.sv - Avalon-MM RGB fade sequencer; PWM pins compiled in with LED_FADE_PWM_EN
module led_fade_sequencer #(
  parameter int PERIOD_W     = 16,
  parameter int RESET_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  red_level,
  output logic [7:0]  green_level,
  output logic [7:0]  blue_level,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        busy,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t              state;
  logic                enable, irq_en, done;
  logic [23:0]         target;
  logic [PERIOD_W-1:0] period, prescaler, reload;
  logic [7:0]          cur_r, cur_g, cur_b, nxt_r, nxt_g, nxt_b;
  logic                wr, ctrl_wr, start, en_next, done_clr, at_target, step_hits;
  logic                unused_wd;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction

  // A CTRL write and start can land on the same edge, so the FSM sees the new enable.
  always_comb begin
    wr        = chipselect & ~write_n;
    ctrl_wr   = wr && (address == 3'd0);
    start     = ctrl_wr & writedata[1];
    en_next   = ctrl_wr ? writedata[0] : enable;
    done_clr  = wr && (address == 3'd4) && writedata[0];
    reload    = (period == '0) ? '0 : period - PERIOD_W'(1);
    at_target = ({cur_r, cur_g, cur_b} == target);
    nxt_r     = step_toward(cur_r, target[23:16]);
    nxt_g     = step_toward(cur_g, target[15:8]);
    nxt_b     = step_toward(cur_b, target[7:0]);
    step_hits = ({nxt_r, nxt_g, nxt_b} == target);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      target    <= '0;
      period    <= PERIOD_W'(RESET_PERIOD);
      prescaler <= '0;
      cur_r     <= '0;
      cur_g     <= '0;
      cur_b     <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= writedata[0];
        irq_en <= writedata[2];
      end
      if (wr && address == 3'd1) target <= writedata[23:0];
      if (wr && address == 3'd2) period <= writedata[PERIOD_W-1:0];
      // Clear first so a same-edge done-set below overrides it.
      if (done_clr) done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && en_next) begin
            if (at_target) done <= 1'b1;
            else begin
              prescaler <= reload;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (start) begin
            prescaler <= reload;
            state     <= en_next ? RUN : PAUSE;
          end else if (!en_next) begin
            state <= PAUSE;
          end else if (prescaler != '0) begin
            prescaler <= prescaler - PERIOD_W'(1);
          end else begin
            cur_r     <= nxt_r;
            cur_g     <= nxt_g;
            cur_b     <= nxt_b;
            prescaler <= reload;
            if (step_hits) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        PAUSE: begin
          if (start) begin
            prescaler <= reload;
            state     <= en_next ? RUN : PAUSE;
          end else if (en_next) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = {29'b0, irq_en, 1'b0, enable};
      3'd1: readdata = {8'b0, target};
      3'd2: readdata = 32'(period);
      3'd3: readdata = {8'b0, cur_r, cur_g, cur_b};
      3'd4: readdata = {30'b0, busy, done};
      default: readdata = '0;
    endcase
  end

  assign busy        = (state != IDLE);
  assign irq         = done & irq_en;
  assign red_level   = cur_r;
  assign green_level = cur_g;
  assign blue_level  = cur_b;
  assign unused_wd   = ^writedata;

`ifdef LED_FADE_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_r = enable & (pwm_cnt < cur_r);
  assign pwm_g = enable & (pwm_cnt < cur_g);
  assign pwm_b = enable & (pwm_cnt < cur_b);
`else
  assign pwm_r = 1'b0;
  assign pwm_g = 1'b0;
  assign pwm_b = 1'b0;
`endif

endmodule
